// File: rtl/cm_frame_tx.sv
// Transmit end of the CM register-frame link: sends header plus register-file words over a 16-bit SPI master.
// Optional build macro CM_TX_CHECKSUM_EN replaces the last payload word with a mod-2^16 sum of the frame.
module cm_frame_tx #(
  parameter logic [15:0] CM_COMMAND   = 16'h434D,
  parameter int          REGISTER_MAX = 50,
  parameter int          CLK_DIV      = 4,
  parameter int          GAP_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [7:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi
);

  typedef enum logic [2:0] {IDLE, LOAD, ASSERT, SHIFT, HOLD, GAP, DONE} state_t;

  localparam logic [7:0]  LAST_IDX = 8'(REGISTER_MAX - 1);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state;
  logic        load_second;
  logic        start_q;
  logic [15:0] div_cnt;
  logic [4:0]  half_cnt;
  logic [15:0] gap_cnt;
  logic [15:0] shreg;
  logic [7:0]  word_idx;
  logic [15:0] word_val;
  logic        fetch_next;
  logic        div_tick;

  assign div_tick = (div_cnt == DIV_LAST);

`ifdef CM_TX_CHECKSUM_EN
  logic [15:0] csum;
  // the word after the current one is fetched unless it is the checksum slot
  assign fetch_next = ((word_idx + 8'd1) != LAST_IDX);
`else
  assign fetch_next = 1'b1;
`endif

  // Select the value loaded into the shift register at the end of LOAD
  always_comb begin
    word_val = rd_data;
    if (word_idx == 8'd0) begin
      word_val = CM_COMMAND;
    end
`ifdef CM_TX_CHECKSUM_EN
    else if (word_idx == LAST_IDX) begin
      word_val = csum;
    end
`endif
    else begin
      word_val = rd_data;
    end
  end

  // Frame sequencer with registered SPI and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      load_second <= 1'b0;
      start_q     <= 1'b0;
      div_cnt     <= 16'd0;
      half_cnt    <= 5'd0;
      gap_cnt     <= 16'd0;
      shreg       <= 16'd0;
      word_idx    <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= 8'd0;
      cs_n        <= 1'b1;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
`ifdef CM_TX_CHECKSUM_EN
      csum        <= 16'd0;
`endif
    end else begin
      start_q <= start;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      case (state)
        IDLE: begin
          // a start still held from an earlier request does not re-arm
          if (start && !start_q) begin
            state       <= LOAD;
            busy        <= 1'b1;
            word_idx    <= 8'd0;
            load_second <= 1'b0;
          end
        end
        LOAD: begin
          if (!load_second) begin
            load_second <= 1'b1;
          end else begin
            load_second <= 1'b0;
            shreg       <= word_val;
            mosi        <= word_val[15];
            cs_n        <= 1'b0;
            div_cnt     <= 16'd0;
            half_cnt    <= 5'd0;
            state       <= ASSERT;
`ifdef CM_TX_CHECKSUM_EN
            csum        <= (word_idx == 8'd0) ? CM_COMMAND : (csum + word_val);
`endif
          end
        end
        ASSERT, SHIFT: begin
          state <= SHIFT;
          if (div_tick) begin
            div_cnt  <= 16'd0;
            sclk     <= ~sclk;
            half_cnt <= half_cnt + 5'd1;
            if (half_cnt == 5'd31) begin
              state <= HOLD;
            end else if (sclk) begin
              shreg <= {shreg[14:0], 1'b0};
              mosi  <= shreg[14];
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (div_tick) begin
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            gap_cnt <= 16'd0;
            div_cnt <= 16'd0;
            state   <= GAP;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (word_idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              word_idx <= word_idx + 8'd1;
              rd_en    <= fetch_next;
              rd_addr  <= word_idx;
              state    <= LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        DONE: begin
          // two cycles: busy drops with the done pulse, starts stay ignored
          if (busy) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cm_frame_tx.sv
// Directed bench for cm_frame_tx: a wide-timing instance and a CLK_DIV=1 corner instance with a cs_n-rise receiver model.
`timescale 1ns/1ps
module tb_cm_frame_tx;

`ifdef CM_TX_CHECKSUM_EN
  localparam int          RB       = 3;
  localparam int          LEN_B    = 111;
  localparam int          NFETCH_A = 2;
  localparam logic [15:0] LAST_A   = 16'hFA03;
  localparam logic [15:0] LAST_B   = 16'h545E;
`else
  localparam int          RB       = 2;
  localparam int          LEN_B    = 75;
  localparam int          NFETCH_A = 3;
  localparam logic [15:0] LAST_A   = 16'hFFFF;
  localparam logic [15:0] LAST_B   = 16'h1111;
`endif

  logic clk, rst;
  logic start_a, busy_a, done_a, rd_en_a, cs_a, sclk_a, mosi_a;
  logic start_b, busy_b, done_b, rd_en_b, cs_b, sclk_b, mosi_b;
  logic [7:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [15:0] mem [3];
  logic [15:0] exp_a [4];
  logic [15:0] exp_b [3];

  int n_pass, n_total, cyc, t0;
  int lowc[2], risec[2], viol[2], nw[2], done_n[2], done_cyc[2];
  logic [15:0] rx[2];
  logic pcs[2], psc[2], pmo[2];
  logic [15:0] words[2][$];
  int lowq[2][$], riseq[2][$];
  int addrq[$];
  logic [1:0] cs_v, sc_v, mo_v, dn_v;

  cm_frame_tx #(.CM_COMMAND(16'h434D), .REGISTER_MAX(4), .CLK_DIV(2), .GAP_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .rd_en(rd_en_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .cs_n(cs_a), .sclk(sclk_a), .mosi(mosi_a));

  cm_frame_tx #(.CM_COMMAND(16'h434D), .REGISTER_MAX(RB), .CLK_DIV(1), .GAP_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .cs_n(cs_b), .sclk(sclk_b), .mosi(mosi_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // register-file models: data valid the cycle after rd_en, noise otherwise
  initial begin
    logic pend; logic [7:0] pa;
    rd_data_a = 16'h0;
    forever begin
      @(negedge clk); pend = rd_en_a; pa = rd_addr_a;
      @(posedge clk); #1;
      rd_data_a = (pend && pa < 8'd3) ? mem[pa] : 16'($urandom);
    end
  end

  initial begin
    logic pend; logic [7:0] pa;
    rd_data_b = 16'h0;
    forever begin
      @(negedge clk); pend = rd_en_b; pa = rd_addr_b;
      @(posedge clk); #1;
      rd_data_b = (pend && pa < 8'd3) ? mem[pa] : 16'($urandom);
    end
  end

  // receiver and timing monitor for both instances
  initial begin
    for (int g = 0; g < 2; g++) begin
      lowc[g] = 0; risec[g] = 0; viol[g] = 0; nw[g] = 0; done_n[g] = 0; done_cyc[g] = 0;
      rx[g] = 16'h0; pcs[g] = 1'b1; psc[g] = 1'b0; pmo[g] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cs_v = {cs_b, cs_a}; sc_v = {sclk_b, sclk_a}; mo_v = {mosi_b, mosi_a}; dn_v = {done_b, done_a};
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          rx[g] = 16'h0; lowc[g] = 0; risec[g] = 0; pcs[g] = 1'b1; psc[g] = 1'b0; pmo[g] = 1'b0;
        end else begin
          if (cs_v[g] && sc_v[g]) viol[g]++;
          if (!cs_v[g]) begin
            lowc[g]++;
            if (sc_v[g] && !psc[g]) begin
              risec[g]++;
              rx[g] = {rx[g][14:0], mo_v[g]};
            end
            if (!pcs[g] && (mo_v[g] != pmo[g]) && !(psc[g] && !sc_v[g])) viol[g]++;
          end
          if (cs_v[g] && !pcs[g]) begin
            words[g].push_back(rx[g]);
            lowq[g].push_back(lowc[g]);
            riseq[g].push_back(risec[g]);
            nw[g]++;
            rx[g] = 16'h0; lowc[g] = 0; risec[g] = 0;
          end
          if (dn_v[g]) begin
            done_n[g]++;
            done_cyc[g] = cyc;
          end
          pcs[g] = cs_v[g]; psc[g] = sc_v[g]; pmo[g] = mo_v[g];
        end
      end
      if (!rst && rd_en_a) addrq.push_back(int'(rd_addr_a));
    end
  end

  initial begin
    n_pass = 0; n_total = 0;
    mem[0] = 16'h1111; mem[1] = 16'hA5A5; mem[2] = 16'hFFFF;
    exp_a[0] = 16'h434D; exp_a[1] = 16'h1111; exp_a[2] = 16'hA5A5; exp_a[3] = LAST_A;
    exp_b[0] = 16'h434D; exp_b[1] = (RB == 3) ? 16'h1111 : LAST_B; exp_b[2] = LAST_B;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    step(3);
    check_eq("rst_cs_n", cs_a, 1'b1);
    check_eq("rst_sclk", sclk_a, 1'b0);
    check_eq("rst_mosi", mosi_a, 1'b0);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_done", done_a, 1'b0);
    check_eq("rst_rd_en", rd_en_a, 1'b0);
    check_eq("rst_rd_addr", rd_addr_a, 8'd0);
    rst = 1'b0;
    step(2);

    // CLK_DIV=1 corner
    start_b = 1'b1; t0 = cyc;
    step(1); start_b = 1'b0;
    for (int i = 0; i < 400 && done_n[1] == 0; i++) step(1);
    check_eq("b_frame_len", done_cyc[1] - t0 + 1, LEN_B);
    check_eq("b_words", nw[1], RB);
    for (int i = 0; i < RB; i++) begin
      check_eq("b_word", words[1][i], exp_b[i]);
      check_eq("b_cs_low", lowq[1][i], 33);
      check_eq("b_rises", riseq[1][i], 16);
    end
    check_eq("b_viol", viol[1], 0);

    // basic frame with held start, a start at cycle 50 and one in the done cycle
    start_a = 1'b1; t0 = cyc;
    step(1);
    check_eq("a_busy_c1", busy_a, 1'b1);
    check_eq("a_no_rd_en_w0", rd_en_a, 1'b0);
    step(2);
    check_eq("a_cs_fall_c3", cs_a, 1'b0);
    start_a = 1'b0;
    step(47); start_a = 1'b1;
    step(1);  start_a = 1'b0;
    step(231);
    check_eq("a_done_c282", done_a, 1'b1);
    check_eq("a_busy_c282", busy_a, 1'b0);
    start_a = 1'b1;
    step(1); start_a = 1'b0;
    step(400);
    check_eq("a_frame_len", done_cyc[0] - t0 + 1, 283);
    check_eq("a_done_count", done_n[0], 1);
    check_eq("a_words", nw[0], 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("a_word", words[0][i], exp_a[i]);
      check_eq("a_cs_low", lowq[0][i], 66);
      check_eq("a_rises", riseq[0][i], 16);
    end
    check_eq("a_rd_count", addrq.size(), NFETCH_A);
    for (int i = 0; i < NFETCH_A; i++) check_eq("a_rd_addr", addrq[i], i);
    check_eq("a_viol", viol[0], 0);

    // reset during word 2, bit 7
    words[0].delete(); lowq[0].delete(); riseq[0].delete();
    nw[0] = 0; done_n[0] = 0;
    start_a = 1'b1;
    step(1); start_a = 1'b0;
    for (int i = 0; i < 2000 && !(nw[0] >= 2 && risec[0] >= 8); i++) @(negedge clk);
    check_eq("mid_reached", (nw[0] >= 2 && risec[0] >= 8), 1'b1);
    rst = 1'b1;
    #1;
    check_eq("mid_cs_n", cs_a, 1'b1);
    check_eq("mid_sclk", sclk_a, 1'b0);
    check_eq("mid_busy", busy_a, 1'b0);
    step(3);
    rst = 1'b0;
    step(20);
    check_eq("mid_no_done", done_n[0], 0);
    check_eq("mid_words", nw[0], 2);
    words[0].delete(); lowq[0].delete(); riseq[0].delete(); nw[0] = 0;
    start_a = 1'b1;
    step(1); start_a = 1'b0;
    step(320);
    check_eq("re_words", nw[0], 4);
    check_eq("re_first", words[0][0], 16'h434D);
    check_eq("re_last", words[0][3], LAST_A);
    check_eq("re_done", done_n[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
